// File: rtl/spi_secondary_mode_if.sv
// spi_secondary_mode_if: SPI pins plus RX/TX word handshakes of the SPI secondary
interface spi_secondary_mode_if #(
  parameter int WORD_BITS = 8
);
  logic                 sck;
  logic                 cs_n;
  logic                 in_bit;
  logic                 out_bit;
  logic                 out_en;
  logic [1:0]           mode;
  logic [WORD_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_overrun;
  logic [WORD_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_underrun;
  logic                 frame_error;
  modport slave (
    input  sck, cs_n, in_bit, mode, rx_ready, tx_data, tx_valid,
    output out_bit, out_en, rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun, frame_error
  );
  modport master (
    output sck, cs_n, in_bit, mode, rx_ready, tx_data, tx_valid,
    input  out_bit, out_en, rx_data, rx_valid, rx_overrun, tx_ready, tx_underrun, frame_error
  );
endinterface

// File: rtl/spi_secondary_mode.sv
// spi_secondary_mode: oversampled SPI secondary, modes 0-3, selectable bit order, valid/ready word handshakes
module spi_secondary_mode #(
  parameter int                   WORD_BITS   = 8,
  parameter bit                   MSB_FIRST   = 1'b1,
  parameter int                   SYNC_STAGES = 2,
  parameter logic [WORD_BITS-1:0] TX_IDLE     = '1
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_secondary_mode_if.slave bus
);
  localparam int CW = $clog2(WORD_BITS);
  typedef enum logic {IDLE, ACTIVE} state_e;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_q, cs_q, din_q;
  logic                   sck_prev_q, cs_prev_q;
  logic [1:0]             mode_q, mode_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WORD_BITS-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic                   done_q, done_d, out_bit_q, out_bit_d, out_en_q, out_en_d;
  logic                   rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
  logic                   tx_rdy_q, tx_rdy_d, tx_unr_q, tx_unr_d, ferr_q, ferr_d;
  logic                   sck_s, cs_s, din_s, cs_fall, cs_rise, edge_v, sample, present, load;
  logic [WORD_BITS-1:0]   tx_word;
  function automatic logic first_bit(input logic [WORD_BITS-1:0] w);
    return MSB_FIRST ? w[WORD_BITS-1] : w[0];
  endfunction
  function automatic logic [WORD_BITS-1:0] shift_out(input logic [WORD_BITS-1:0] w);
    return MSB_FIRST ? {w[WORD_BITS-2:0], 1'b0} : {1'b0, w[WORD_BITS-1:1]};
  endfunction
  assign sck_s   = sck_q[SYNC_STAGES-1];
  assign cs_s    = cs_q[SYNC_STAGES-1];
  assign din_s   = din_q[SYNC_STAGES-1];
  assign cs_fall = (state_q == IDLE) && !cs_s && cs_prev_q;
  assign cs_rise = (state_q == ACTIVE) && cs_s && !cs_prev_q;
  // a chip-select rise in the same cycle swallows any sck edge
  assign edge_v  = (state_q == ACTIVE) && !cs_rise && (sck_s ^ sck_prev_q);
  assign sample  = edge_v && ((sck_s != mode_q[1]) ^ mode_q[0]);
  assign present = edge_v && !((sck_s != mode_q[1]) ^ mode_q[0]);
  assign load    = cs_fall || (done_q && (state_q == ACTIVE) && !cs_rise);
  assign tx_word = bus.tx_valid ? bus.tx_data : TX_IDLE;
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    cnt_d      = cnt_q;
    tx_sh_d    = load ? tx_word : tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = done_q ? rx_sh_q : rx_data_q;
    rx_valid_d = done_q || (rx_valid_q && !bus.rx_ready);
    rx_ovr_d   = done_q && rx_valid_q && !bus.rx_ready;
    tx_rdy_d   = load && bus.tx_valid;
    tx_unr_d   = load && !bus.tx_valid;
    done_d     = 1'b0;
    out_bit_d  = out_bit_q;
    out_en_d   = out_en_q;
    ferr_d     = 1'b0;
    if (cs_fall) begin
      state_d   = ACTIVE;
      mode_d    = bus.mode;
      cnt_d     = '0;
      out_en_d  = 1'b1;
      out_bit_d = bus.mode[0] ? out_bit_q : first_bit(tx_word);
      tx_sh_d   = bus.mode[0] ? tx_word : shift_out(tx_word);
    end
    if (cs_rise) begin
      state_d   = IDLE;
      out_en_d  = 1'b0;
      out_bit_d = 1'b0;
      ferr_d    = cnt_q != '0;
      cnt_d     = '0;
    end
    if (present) begin
      out_bit_d = first_bit(tx_sh_q);
      tx_sh_d   = shift_out(tx_sh_q);
    end
    if (sample) begin
      rx_sh_d = MSB_FIRST ? {rx_sh_q[WORD_BITS-2:0], din_s} : {din_s, rx_sh_q[WORD_BITS-1:1]};
      done_d  = cnt_q == CW'(WORD_BITS - 1);
      cnt_d   = done_d ? '0 : cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_q      <= '0;
      cs_q       <= '1;
      din_q      <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
      state_q    <= IDLE;
      mode_q     <= '0;
      cnt_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      done_q     <= 1'b0;
      out_bit_q  <= 1'b0;
      out_en_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
      tx_rdy_q   <= 1'b0;
      tx_unr_q   <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sck_q      <= {sck_q[SYNC_STAGES-2:0], bus.sck};
      cs_q       <= {cs_q[SYNC_STAGES-2:0], bus.cs_n};
      din_q      <= {din_q[SYNC_STAGES-2:0], bus.in_bit};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= cnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      done_q     <= done_d;
      out_bit_q  <= out_bit_d;
      out_en_q   <= out_en_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q   <= rx_ovr_d;
      tx_rdy_q   <= tx_rdy_d;
      tx_unr_q   <= tx_unr_d;
      ferr_q     <= ferr_d;
    end
  end
  assign bus.out_bit     = out_bit_q;
  assign bus.out_en      = out_en_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = rx_ovr_q;
  assign bus.tx_ready    = tx_rdy_q;
  assign bus.tx_underrun = tx_unr_q;
  assign bus.frame_error = ferr_q;
endmodule
